// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO unit: EX operation codes and controller states.
package hilo_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ABORT  = 2'd3
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register pair beside the EX-stage ALU; captures products, serves MF/MT,
// and is the requesting side of the external multi-cycle divider.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         op_valid,
  input  logic [3:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic [W-1:0] mul_lo,
  input  logic [W-1:0] mul_hi,
  output logic         div_start,
  output logic         div_signed,
  output logic [W-1:0] div_x,
  output logic [W-1:0] div_y,
  input  logic         div_done,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  output logic         stall,
  output logic [W-1:0] mf_data,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_e       r_state;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_div_x;
  logic [W-1:0] r_div_y;
  logic         r_div_signed;
  logic         r_div_start;

  op_e          w_op;
  logic         w_act;
  logic         w_stall;
  logic [W-1:0] w_mf_data;

  assign w_op  = op_e'(op);
  assign w_act = op_valid & ~flush;

  // While an orphaned divide drains, any real instruction is held so it cannot
  // touch HI/LO or start a second divide underneath it.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:   w_stall = w_act & is_div_op(w_op);
      ST_LAUNCH: w_stall = 1'b1;
      ST_WAIT:   w_stall = ~div_done;
      ST_ABORT:  w_stall = op_valid & (w_op != OP_NOP);
      default:   w_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_mf_data = '0;
    if (w_op == OP_MFHI) begin
      w_mf_data = r_hi;
    end else if (w_op == OP_MFLO) begin
      w_mf_data = r_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hi         <= '0;
      r_lo         <= '0;
      r_div_x      <= '0;
      r_div_y      <= '0;
      r_div_signed <= 1'b0;
      r_div_start  <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_act) begin
            case (w_op)
              OP_DIV, OP_DIVU: begin
                r_div_x      <= rs_val;
                r_div_y      <= rt_val;
                r_div_signed <= (w_op == OP_DIV);
                r_div_start  <= 1'b1;
                r_state      <= ST_LAUNCH;
              end
              OP_MULT, OP_MULTU: begin
                r_hi <= mul_hi;
                r_lo <= mul_lo;
              end
              OP_MTHI: r_hi <= rs_val;
              OP_MTLO: r_lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_LAUNCH: begin
          r_state <= flush ? ST_ABORT : ST_WAIT;
        end
        ST_WAIT: begin
          // A flush landing on the completion cycle still discards the result.
          if (div_done) begin
            if (!flush) begin
              r_lo <= div_q;
              r_hi <= div_r;
            end
            r_state <= ST_IDLE;
          end else if (flush) begin
            r_state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (div_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign div_start  = r_div_start;
  assign div_signed = r_div_signed;
  assign div_x      = r_div_x;
  assign div_y      = r_div_y;
  assign stall      = w_stall;
  assign mf_data    = w_mf_data;
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed instructions push expected retirements
// and divider launches; independent monitors pop and compare.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         op_valid;
  logic [3:0]   op;
  logic [W-1:0] rs_val, rt_val, mul_lo, mul_hi;
  logic         div_start, div_signed;
  logic [W-1:0] div_x, div_y;
  logic         div_done;
  logic [W-1:0] div_q, div_r;
  logic         stall;
  logic [W-1:0] mf_data, hi, lo;

  hilo_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .stall(stall), .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_mf;
    logic [31:0] exp_mf;
    int          exp_stalls;
    bit          chk_hl;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } ret_t;

  typedef struct {
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
  } start_t;

  ret_t   ret_q[$];
  string  name_q[$];
  start_t start_q[$];

  int checks = 0;
  int errors = 0;
  int starts_seen = 0;
  int div_lat = 4;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic exp_ret(input string nm, input bit cm, input logic [31:0] mf, input int st,
                         input bit ch, input logic [31:0] eh, input logic [31:0] el);
    ret_t r;
    r.chk_mf = cm; r.exp_mf = mf; r.exp_stalls = st;
    r.chk_hl = ch; r.exp_hi = eh; r.exp_lo = el;
    ret_q.push_back(r);
    name_q.push_back(nm);
  endtask

  task automatic exp_start(input logic s, input logic [31:0] x, input logic [31:0] y);
    start_t t;
    t.sgn = s; t.x = x; t.y = y;
    start_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt);
    op_valid = 1'b1; op = o; rs_val = rs; rt_val = rt;
  endtask

  // Present one instruction and hold it until it is no longer stalled.
  task automatic issue(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] mh, input logic [31:0] ml);
    int n;
    n = 0;
    set_op(o, rs, rt);
    mul_hi = mh; mul_lo = ml;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (stall) begin
      checks++; errors++;
      $display("FAIL issue_timeout: op %0d stalled for %0d cycles, required release", o, n);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
  endtask

  // Behavioral divider: done pulses div_lat cycles after the start cycle.
  initial begin
    logic [31:0] x, y, q, r;
    logic        s;
    int          lat;
    div_done = 1'b0; div_q = '0; div_r = '0;
    forever begin
      @(negedge clk);
      if (div_start) begin
        x = div_x; y = div_y; s = div_signed; lat = div_lat;
        if (y == 0) begin
          q = '1; r = x;
        end else if (s) begin
          q = 32'($signed(x) / $signed(y));
          r = 32'($signed(x) % $signed(y));
        end else begin
          q = x / y;
          r = x % y;
        end
        repeat (lat) @(posedge clk);
        #1;
        div_done = 1'b1; div_q = q; div_r = r;
        @(posedge clk);
        #1;
        div_done = 1'b0; div_q = 32'hDEAD_0000; div_r = 32'hDEAD_0001;
      end
    end
  end

  // Launch monitor: each start must match a queued launch and be a single pulse.
  initial begin
    bit     prev;
    start_t t;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && div_start) begin
        starts_seen++;
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL start_pulse_width: div_start high 2 cycles, required 1");
        end
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: div_x=0x%08h div_y=0x%08h, required no start", div_x, div_y);
        end else begin
          t = start_q.pop_front();
          check32("start div_signed", 32'(div_signed), 32'(t.sgn));
          check32("start div_x", div_x, t.x);
          check32("start div_y", div_y, t.y);
        end
      end
      prev = div_start;
    end
  end

  // Retirement monitor: an instruction retires when valid, unflushed and not stalled.
  initial begin
    int          stall_cnt;
    bit          hl_pend;
    logic [31:0] hl_hi, hl_lo;
    string       hl_name, nm;
    ret_t        r;
    stall_cnt = 0; hl_pend = 0; hl_hi = '0; hl_lo = '0; hl_name = "";
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        hl_pend = 0;
      end else begin
        if (hl_pend) begin
          check32({hl_name, " hi"}, hi, hl_hi);
          check32({hl_name, " lo"}, lo, hl_lo);
          hl_pend = 0;
        end
        if (op_valid && flush) begin
          stall_cnt = 0;
        end else if (op_valid && stall) begin
          stall_cnt++;
        end else if (op_valid) begin
          if (ret_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: op %0d retired, required none", op);
          end else begin
            r  = ret_q.pop_front();
            nm = name_q.pop_front();
            if (r.chk_mf) check32({nm, " mf_data"}, mf_data, r.exp_mf);
            check32({nm, " stall_cycles"}, 32'(stall_cnt), 32'(r.exp_stalls));
            if (r.chk_hl) begin
              hl_pend = 1; hl_hi = r.exp_hi; hl_lo = r.exp_lo; hl_name = nm;
            end
            $display("retire %s after %0d stall cycles", nm, stall_cnt);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  localparam logic [31:0] HI_OLD = 32'h0BAD_F00D;
  localparam logic [31:0] LO_OLD = 32'h1234_5678;

  initial begin
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = OP_NOP;
    rs_val = '0; rt_val = '0; mul_lo = '0; mul_hi = '0;

    @(posedge clk);
    @(negedge clk);
    check32("reset hi", hi, 32'h0);
    check32("reset lo", lo, 32'h0);
    check32("reset div_x", div_x, 32'h0);
    check32("reset div_y", div_y, 32'h0);
    check32("reset div_signed", 32'(div_signed), 32'h0);
    check32("reset div_start", 32'(div_start), 32'h0);
    check32("reset stall", 32'(stall), 32'h0);
    check32("reset mf_data", mf_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Products land at the issue edge and are readable the very next cycle.
    exp_ret("MULT", 0, '0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(OP_MULT, '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    exp_ret("MFHI after MULT", 1, 32'hFFFF_FFFF, 0, 0, '0, '0);
    issue(OP_MFHI, '0, '0, '0, '0);
    exp_ret("MFLO after MULT", 1, 32'hFFFF_FFFE, 0, 0, '0, '0);
    issue(OP_MFLO, '0, '0, '0, '0);

    div_lat = 32;
    exp_start(1'b0, 32'd100, 32'd7);
    exp_ret("DIVU 100/7", 0, '0, 33, 1, 32'd2, 32'd14);
    issue(OP_DIVU, 32'd100, 32'd7, '0, '0);
    exp_ret("MFLO after DIVU", 1, 32'd14, 0, 0, '0, '0);
    issue(OP_MFLO, '0, '0, '0, '0);

    div_lat = 5;
    exp_start(1'b1, 32'hFFFF_FFF9, 32'd2);
    exp_ret("DIV -7/2", 0, '0, 6, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0);

    exp_ret("MTLO", 0, '0, 0, 1, 32'hFFFF_FFFF, LO_OLD);
    issue(OP_MTLO, LO_OLD, '0, '0, '0);
    exp_ret("MTHI", 0, '0, 0, 1, HI_OLD, LO_OLD);
    issue(OP_MTHI, HI_OLD, '0, '0, '0);

    // Flushed MTHI in IDLE must not write.
    set_op(OP_MTHI, 32'hDEAD_BEEF, '0);
    flush = 1'b1;
    step();
    flush = 1'b0; op_valid = 1'b0; op = OP_NOP;
    exp_ret("MFHI after flushed MTHI", 1, HI_OLD, 0, 0, '0, '0);
    issue(OP_MFHI, '0, '0, '0, '0);

    // Flush in the third WAIT cycle; the following MFLO drains the orphan first.
    div_lat = 10;
    exp_start(1'b0, 32'd50, 32'd5);
    set_op(OP_DIVU, 32'd50, 32'd5);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_ret("MFLO after WAIT flush", 1, LO_OLD, 7, 1, HI_OLD, LO_OLD);
    issue(OP_MFLO, '0, '0, '0, '0);

    // Flush on the same cycle as div_done.
    div_lat = 4;
    exp_start(1'b0, 32'd9, 32'd4);
    set_op(OP_DIVU, 32'd9, 32'd4);
    repeat (5) step();
    flush = 1'b1;
    @(negedge clk);
    check32("flush+done stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; op_valid = 1'b0; op = OP_NOP;
    exp_ret("MFHI after flush+done", 1, HI_OLD, 0, 1, HI_OLD, LO_OLD);
    issue(OP_MFHI, '0, '0, '0, '0);
    exp_ret("MFLO after flush+done", 1, LO_OLD, 0, 0, '0, '0);
    issue(OP_MFLO, '0, '0, '0, '0);

    exp_ret("MTHI A5", 0, '0, 0, 1, 32'hA5A5_A5A5, LO_OLD);
    issue(OP_MTHI, 32'hA5A5_A5A5, '0, '0, '0);
    exp_ret("MFHI after MTHI A5", 1, 32'hA5A5_A5A5, 0, 0, '0, '0);
    issue(OP_MFHI, '0, '0, '0, '0);

    // Reset in WAIT; the late div_done must be ignored.
    div_lat = 20;
    exp_start(1'b0, 32'd77, 32'd3);
    set_op(OP_DIVU, 32'd77, 32'd3);
    repeat (6) step();
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP;
    @(negedge clk);
    check32("mid-WAIT reset hi", hi, 32'h0);
    check32("mid-WAIT reset lo", lo, 32'h0);
    check32("mid-WAIT reset stall", 32'(stall), 32'h0);
    check32("mid-WAIT reset div_start", 32'(div_start), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) step();
    check32("late done hi", hi, 32'h0);
    check32("late done lo", lo, 32'h0);
    check32("late done stall", 32'(stall), 32'h0);
    exp_ret("MFHI after reset", 1, 32'h0, 0, 1, 32'h0, 32'h0);
    issue(OP_MFHI, '0, '0, '0, '0);

    repeat (3) step();
    check32("total div_start pulses", 32'(starts_seen), 32'd5);
    check32("pending retirements", 32'(ret_q.size()), 32'd0);
    check32("pending launches", 32'(start_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
